// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer and its down counters.
// State encodings are fixed so the FSM encoding matches the original defines.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_GAP   = 2'b10
    } state_t;

    localparam int unsigned GAP_W = 4;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter with a zero flag; used for both the bit count and the gap count.
// The caller never decrements at zero, so the count only wraps through a reload.
module bit_down_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the 110-sequence detector: valid/ready word input,
// one bit per clk on sout, gap-free across back-to-back words when IDLE_GAP is 0.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned IDLE_GAP   = 0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             bit_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    // The IDLE cycle that precedes every accept already emits one idle bit,
    // so GAP itself only needs to cover the remaining IDLE_GAP-1 cycles.
    localparam bit               USE_GAP  = (IDLE_GAP > 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = USE_GAP ? GAP_W'(IDLE_GAP - 2) : '0;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic             r_sout, r_bit_valid, r_last;
    logic             w_sout_nxt, w_bit_valid_nxt, w_last_nxt;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero, w_cnt_zero_nxt, w_cnt_load, w_cnt_dec;
    logic [GAP_W-1:0] w_gap;
    logic             w_gap_zero, w_gap_load, w_gap_dec;
    logic             w_accept;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    bit_down_counter #(.W(CNT_W)) u_bit_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_cnt_load),
        .i_value (CNT_LOAD),
        .i_dec   (w_cnt_dec),
        .o_count (w_cnt),
        .o_zero  (w_cnt_zero)
    );

    bit_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_gap_load),
        .i_value (GAP_LOAD),
        .i_dec   (w_gap_dec),
        .o_count (w_gap),
        .o_zero  (w_gap_zero)
    );

    assign din_ready = reset && ((r_state == S_IDLE) ||
                       (r_state == S_SHIFT && w_cnt_zero && IDLE_GAP == 0));
    assign w_accept  = din_ready && din_valid;

    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_cnt_load     = 1'b0;
        w_cnt_dec      = 1'b0;
        w_cnt_zero_nxt = w_cnt_zero;
        w_gap_load     = 1'b0;
        w_gap_dec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = S_SHIFT;
                    w_shreg_nxt    = din;
                    w_cnt_load     = 1'b1;
                    w_cnt_zero_nxt = 1'b0;
                end
            end
            S_SHIFT: begin
                if (!w_cnt_zero) begin
                    w_shreg_nxt    = advance(r_shreg);
                    w_cnt_dec      = 1'b1;
                    w_cnt_zero_nxt = (w_cnt == CNT_W'(1));
                end else if (w_accept) begin
                    w_shreg_nxt    = din;
                    w_cnt_load     = 1'b1;
                    w_cnt_zero_nxt = 1'b0;
                end else begin
                    w_shreg_nxt = '0;
                    w_gap_load  = USE_GAP;
                    w_state_nxt = USE_GAP ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                w_gap_dec = (w_gap != '0);
                if (w_gap_zero) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output flops are loaded with the values that belong to the upcoming cycle.
    always_comb begin
        w_bit_valid_nxt = (w_state_nxt == S_SHIFT);
        w_last_nxt      = w_bit_valid_nxt && w_cnt_zero_nxt;
        w_sout_nxt      = w_bit_valid_nxt ? head(w_shreg_nxt) : IDLE_LEVEL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_sout      <= IDLE_LEVEL;
            r_bit_valid <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_sout      <= w_sout_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_last      <= w_last_nxt;
        end
    end

    assign sout      = r_sout;
    assign bit_valid = r_bit_valid;
    assign last      = r_last;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: three configurations (default, IDLE_GAP=3, LSB-first)
// with directed words; a negedge monitor pops expected {sout,last} pairs for every valid bit.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din   [3];
    logic       valid [3];
    logic       ready [3];
    logic       sout  [3];
    logic       bv    [3];
    logic       last  [3];
    logic       busy  [3];

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] q2[$];

    logic [2:0] hist    [3];
    int         det     [3];
    int         det_pos [3];
    int         bitpos  [3];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_GAP(0), .IDLE_LEVEL(1'b0)) u_d0 (
        .clk(clk), .reset(reset), .din(din[0]), .din_valid(valid[0]), .din_ready(ready[0]),
        .sout(sout[0]), .bit_valid(bv[0]), .last(last[0]), .busy(busy[0]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_GAP(3), .IDLE_LEVEL(1'b0)) u_d1 (
        .clk(clk), .reset(reset), .din(din[1]), .din_valid(valid[1]), .din_ready(ready[1]),
        .sout(sout[1]), .bit_valid(bv[1]), .last(last[1]), .busy(busy[1]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_GAP(0), .IDLE_LEVEL(1'b0)) u_d2 (
        .clk(clk), .reset(reset), .din(din[2]), .din_valid(valid[2]), .din_ready(ready[2]),
        .sout(sout[2]), .bit_valid(bv[2]), .last(last[2]), .busy(busy[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input int d, input logic [7:0] w);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b = (d == 2) ? w[i] : w[7-i];
            case (d)
                0:       q0.push_back({b, i == 7});
                1:       q1.push_back({b, i == 7});
                default: q2.push_back({b, i == 7});
            endcase
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input int d, input logic [7:0] w, input bit hold, output int waited);
        waited = 0;
        din[d] = w;
        valid[d] = 1'b1;
        @(negedge clk);
        while (!ready[d] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!ready[d]) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout d%0d: ready never rose, expected 1", d);
            valid[d] = 1'b0;
            return;
        end
        push_word(d, w);
        @(posedge clk);
        #1;
        if (!hold) valid[d] = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Scoreboard monitor and a behavioural 110 detector fed from sout every cycle.
    always @(negedge clk) begin
        logic       have;
        logic [1:0] e;
        for (int d = 0; d < 3; d++) begin
            hist[d] = {hist[d][1:0], sout[d]};
            if (reset && hist[d] == 3'b110) begin
                det[d]++;
                det_pos[d] = bitpos[d];
            end
            if (bv[d] === 1'b1) begin
                have = 1'b0;
                e = '0;
                case (d)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                endcase
                if (!have) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_bit d%0d: got sout=%0b last=%0b, expected no valid bit",
                             d, sout[d], last[d]);
                end else begin
                    check($sformatf("d%0d_bit%0d_sout_last", d, bitpos[d]), {30'd0, sout[d], last[d]}, {30'd0, e});
                end
                bitpos[d]++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         waited, base_det, base_pos, run1, zeros, run2, phase;
        logic [1:0] bvs [40];
        for (int d = 0; d < 3; d++) begin
            din[d] = '0;
            valid[d] = 1'b0;
            hist[d] = '0;
        end

        // Reset state
        #2;
        check("rst_sout", sout[0], 1'b0);
        check("rst_bit_valid", bv[0], 1'b0);
        check("rst_last", last[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_ready_low", ready[0], 1'b0);
        #10 reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", ready[0], 1'b1);

        // 1. Reset in the middle of a word
        @(posedge clk); #1;
        send(0, 8'hA5, 1'b0, waited);
        wait_neg(4);
        #1 reset = 1'b0;
        #1;
        check("midrst_sout", sout[0], 1'b0);
        check("midrst_bit_valid", bv[0], 1'b0);
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_ready", ready[0], 1'b0);
        q0.delete();
        @(negedge clk);
        check("midrst_ready_held", ready[0], 1'b0);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_release_ready", ready[0], 1'b1);
        check("midrst_release_bv", bv[0], 1'b0);

        // 2. Single word, MSB first; 01101100 holds two 110 patterns
        @(posedge clk); #1;
        base_det = det[0];
        send(0, 8'b0110_1100, 1'b0, waited);
        wait_neg(10);
        check("single_det_pulses", det[0] - base_det, 2);
        check("single_idle_bv", bv[0], 1'b0);

        // 3. Back-to-back words with valid held
        @(posedge clk); #1;
        send(0, 8'hC3, 1'b1, waited);
        send(0, 8'h3C, 1'b0, waited);
        check("b2b_ready_wait", waited, 7);
        run1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bv[0]) run1++;
        end
        check("b2b_word2_contig", run1, 8);
        @(negedge clk);
        check("b2b_end_bv", bv[0], 1'b0);
        check("b2b_end_busy", busy[0], 1'b0);

        // 4. IDLE_GAP=3 between two words
        @(posedge clk); #1;
        send(1, 8'hA5, 1'b1, waited);
        din[1] = 8'h81;
        push_word(1, 8'h81);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bvs[c] = {1'b0, bv[1]};
            if (busy[1] && !bv[1]) begin
                check("gap_ready_low", ready[1], 1'b0);
                check("gap_sout_idle", sout[1], 1'b0);
            end
            if (ready[1] && valid[1]) begin
                @(posedge clk);
                #1 valid[1] = 1'b0;
            end
        end
        run1 = 0; zeros = 0; run2 = 0; phase = 0;
        for (int c = 0; c < 30; c++) begin
            case (phase)
                0: if (bvs[c][0]) run1++; else phase = 1;
                1: if (bvs[c][0]) begin run2++; phase = 2; end else zeros++;
                2: if (bvs[c][0]) run2++; else phase = 3;
                default: ;
            endcase
            if (phase == 1 && !bvs[c][0] && c > 0 && bvs[c-1][0]) zeros = 1;
        end
        check("gap_word1_bits", run1, 8);
        check("gap_idle_cycles", zeros, 3);
        check("gap_word2_bits", run2, 8);

        // 5. Backpressure: din changes while not ready, only the ready-time word is taken
        @(posedge clk); #1;
        send(0, 8'h5A, 1'b1, waited);
        for (int i = 0; i < 5; i++) begin
            din[0] = 8'hF0 ^ 8'(i * 37);
            @(negedge clk);
            check("bp_ready_low", ready[0], 1'b0);
            @(posedge clk); #1;
        end
        send(0, 8'h96, 1'b0, waited);
        wait_neg(10);

        // 6. LSB first, 00000110 -> 0,1,1,0,...; detector fires on the 4th bit
        @(posedge clk); #1;
        base_det = det[2];
        base_pos = bitpos[2];
        send(2, 8'b0000_0110, 1'b0, waited);
        wait_neg(10);
        check("lsb_det_pulses", det[2] - base_det, 1);
        check("lsb_det_position", det_pos[2] - base_pos, 3);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
